amp_multi_ctrl: RTL and testbench

Parametrised, multi-channel successor to the single-amplifier state control in the amp_frontend.
- Runs one independent amplifier state machine per channel. Each channel drives active-low enable and mute outputs for its power stage.
- Arbitrates configuration requests from all channels onto the one shared amp_i2c_master, using a req/done handshake.
- Adds behaviour the single-channel control lacks: lock debounce, timed unmute, fault retry with lockout, and config error/timeout handling.

---
 rtl/amp_multi_ctrl_pkg.sv | 19 +
 rtl/amp_ch_fsm.sv | 141 ++++++++++++++
 rtl/amp_multi_ctrl.sv | 123 ++++++++++++
 tb/tb_amp_multi_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/amp_multi_ctrl_pkg.sv
// Shared types and helpers for the multi-channel amplifier controller.
// Holds the channel state encoding and the counter-width helper.
package amp_multi_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_CFG     = 3'd1,
    ST_ENMUTE  = 3'd2,
    ST_PLAY    = 3'd3,
    ST_FAULT   = 3'd4,
    ST_LOCKOUT = 3'd5
  } ch_state_e;

  // Width of a counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/amp_ch_fsm.sv
// One amplifier channel: nerror synchroniser, mute/timeout/retry counters
// and the OFF/CFG/ENMUTE/PLAY/FAULT/LOCKOUT state machine.
module amp_ch_fsm
  import amp_multi_ctrl_pkg::*;
#(
  parameter int MUTE_DELAY_CYC  = 256,
  parameter int CFG_TIMEOUT_CYC = 65536,
  parameter int RETRY_WAIT_CYC  = 4096,
  parameter int RETRY_MAX       = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic locked_i,
  input  logic lock_ok_i,
  input  logic nerror_i,
  input  logic clear_fault_i,
  input  logic grant_i,
  input  logic done_i,
  input  logic err_i,
  output logic req_o,
  output logic timeout_o,
  output logic nenable_o,
  output logic nmute_o,
  output logic fault_o
);

  localparam int MUTE_W = cnt_w(MUTE_DELAY_CYC);
  localparam int TMO_W  = cnt_w(CFG_TIMEOUT_CYC);
  localparam int WAIT_W = cnt_w(RETRY_WAIT_CYC);
  localparam int RTY_W  = cnt_w(RETRY_MAX);

  ch_state_e          state_q, state_d;
  logic [1:0]         sync_q;
  logic [MUTE_W-1:0]  mute_q, mute_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic               err_s;
  logic               timeout_s;

  assign err_s     = ~sync_q[1];
  assign timeout_s = (state_q == ST_CFG) && grant_i && !done_i &&
                     (tmo_q == TMO_W'(CFG_TIMEOUT_CYC - 1));
  assign timeout_o = timeout_s;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_OFF;
      sync_q  <= 2'b11;
      mute_q  <= '0;
      tmo_q   <= '0;
      wait_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], nerror_i};
      mute_q  <= mute_d;
      tmo_q   <= tmo_d;
      wait_q  <= wait_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mute_d  = mute_q;
    tmo_d   = tmo_q;
    wait_d  = wait_q;
    retry_d = retry_q;
    // A synchronised error overrides every other transition outside FAULT/LOCKOUT.
    if (err_s && (state_q != ST_FAULT) && (state_q != ST_LOCKOUT)) begin
      state_d = ST_FAULT;
      mute_d  = '0;
      tmo_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (lock_ok_i) state_d = ST_CFG;
          else           state_d = ST_OFF;
        end
        ST_CFG: begin
          if (grant_i && done_i) begin
            state_d = err_i ? ST_FAULT : ST_ENMUTE;
            tmo_d   = '0;
          end else if (timeout_s) begin
            state_d = ST_FAULT;
            tmo_d   = '0;
          end else if (grant_i) begin
            tmo_d = tmo_q + TMO_W'(1);
          end else begin
            tmo_d = tmo_q;
          end
        end
        ST_ENMUTE: begin
          if (!locked_i) begin
            mute_d = '0;
          end else if (mute_q == MUTE_W'(MUTE_DELAY_CYC - 1)) begin
            state_d = ST_PLAY;
            mute_d  = '0;
            retry_d = '0;
          end else begin
            mute_d = mute_q + MUTE_W'(1);
          end
        end
        ST_PLAY: begin
          if (!locked_i) state_d = ST_ENMUTE;
          else           state_d = ST_PLAY;
        end
        ST_FAULT: begin
          if (wait_q == WAIT_W'(RETRY_WAIT_CYC - 1)) begin
            wait_d = '0;
            if (retry_q == RTY_W'(RETRY_MAX)) begin
              state_d = ST_LOCKOUT;
            end else begin
              retry_d = retry_q + RTY_W'(1);
              state_d = ST_OFF;
            end
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (clear_fault_i) begin
            state_d = ST_OFF;
            retry_d = '0;
          end else begin
            state_d = ST_LOCKOUT;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign req_o     = (state_q == ST_CFG);
  assign nenable_o = !((state_q == ST_ENMUTE) || (state_q == ST_PLAY));
  assign nmute_o   = (state_q == ST_PLAY);
  assign fault_o   = (state_q == ST_FAULT) || (state_q == ST_LOCKOUT);

endmodule

// File: rtl/amp_multi_ctrl.sv
// Multi-channel amplifier controller top: lock debounce, round-robin
// arbitration of channel config requests onto one i2c master, output packing.
module amp_multi_ctrl
  import amp_multi_ctrl_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int LOCK_WAIT_CYC   = 1024,
  parameter int MUTE_DELAY_CYC  = 256,
  parameter int CFG_TIMEOUT_CYC = 65536,
  parameter int RETRY_WAIT_CYC  = 4096,
  parameter int RETRY_MAX       = 3,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            audio_locked_in,
  input  logic [N_CH-1:0] nerror_in,
  input  logic [N_CH-1:0] clear_fault_in,
  output logic [N_CH-1:0] nenable_out,
  output logic [N_CH-1:0] nmute_out,
  output logic            cfg_req_out,
  output logic [CH_W-1:0] cfg_ch_out,
  input  logic            cfg_done_in,
  input  logic            cfg_err_in,
  output logic [N_CH-1:0] fault_out
);

  localparam int LOCK_W = cnt_w(LOCK_WAIT_CYC);

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              lock_ok_s;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   ch_q, ch_d, last_q, last_d, pick_s;
  logic              found_s;
  logic [N_CH-1:0]   req_s, grant_s, timeout_s;
  int                idx_s;

  assign lock_ok_s = (lock_cnt_q == LOCK_W'(LOCK_WAIT_CYC));

  always_ff @(posedge clk_in) begin
    if (reset) begin
      lock_cnt_q <= '0;
      busy_q     <= 1'b0;
      ch_q       <= '0;
      last_q     <= CH_W'(N_CH - 1);
    end else begin
      lock_cnt_q <= lock_cnt_d;
      busy_q     <= busy_d;
      ch_q       <= ch_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (!audio_locked_in) lock_cnt_d = '0;
    else if (lock_ok_s)   lock_cnt_d = lock_cnt_q;
    else                  lock_cnt_d = lock_cnt_q + LOCK_W'(1);
  end

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found_s = 1'b0;
    pick_s  = last_q;
    idx_s   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx_s = (int'(last_q) + k) % N_CH;
      if (!found_s && req_s[idx_s]) begin
        found_s = 1'b1;
        pick_s  = CH_W'(idx_s);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant is held until done or the granted channel times out; never granted on the release edge.
  always_comb begin
    busy_d = busy_q;
    ch_d   = ch_q;
    last_d = last_q;
    if (busy_q) begin
      if (cfg_done_in || (|(timeout_s & grant_s))) busy_d = 1'b0;
      else                                         busy_d = 1'b1;
    end else if (found_s) begin
      busy_d = 1'b1;
      ch_d   = pick_s;
      last_d = pick_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign grant_s[g] = busy_q && (ch_q == CH_W'(g));

    amp_ch_fsm #(
      .MUTE_DELAY_CYC  (MUTE_DELAY_CYC),
      .CFG_TIMEOUT_CYC (CFG_TIMEOUT_CYC),
      .RETRY_WAIT_CYC  (RETRY_WAIT_CYC),
      .RETRY_MAX       (RETRY_MAX)
    ) u_ch (
      .clk_i         (clk_in),
      .reset_i       (reset),
      .locked_i      (audio_locked_in),
      .lock_ok_i     (lock_ok_s),
      .nerror_i      (nerror_in[g]),
      .clear_fault_i (clear_fault_in[g]),
      .grant_i       (grant_s[g]),
      .done_i        (cfg_done_in),
      .err_i         (cfg_err_in),
      .req_o         (req_s[g]),
      .timeout_o     (timeout_s[g]),
      .nenable_o     (nenable_out[g]),
      .nmute_o       (nmute_out[g]),
      .fault_o       (fault_out[g])
    );
  end

  assign cfg_req_out = busy_q;
  assign cfg_ch_out  = ch_q;

endmodule

// File: tb/tb_amp_multi_ctrl.sv
// Directed bench for amp_multi_ctrl with short timing parameters.
module tb_amp_multi_ctrl;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       audio_locked_in;
  logic [1:0] nerror_in;
  logic [1:0] clear_fault_in;
  logic [1:0] nenable_out;
  logic [1:0] nmute_out;
  logic       cfg_req_out;
  logic [0:0] cfg_ch_out;
  logic       cfg_done_in;
  logic       cfg_err_in;
  logic [1:0] fault_out;

  int checks   = 0;
  int failures = 0;

  amp_multi_ctrl #(
    .N_CH(2), .LOCK_WAIT_CYC(8), .MUTE_DELAY_CYC(4),
    .CFG_TIMEOUT_CYC(20), .RETRY_WAIT_CYC(10), .RETRY_MAX(1)
  ) dut (
    .clk_in(clk_in), .reset(reset), .audio_locked_in(audio_locked_in),
    .nerror_in(nerror_in), .clear_fault_in(clear_fault_in),
    .nenable_out(nenable_out), .nmute_out(nmute_out),
    .cfg_req_out(cfg_req_out), .cfg_ch_out(cfg_ch_out),
    .cfg_done_in(cfg_done_in), .cfg_err_in(cfg_err_in), .fault_out(fault_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic pulse_done(input logic err);
    cfg_done_in = 1'b1;
    cfg_err_in  = err;
    tick(1);
    cfg_done_in = 1'b0;
    cfg_err_in  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; audio_locked_in = 1'b0; nerror_in = 2'b11;
    clear_fault_in = 2'b00; cfg_done_in = 1'b0; cfg_err_in = 1'b0;
    tick(3);
    checks++; if (nenable_out !== 2'b11) begin failures++; $display("FAIL reset_nen got=%b exp=11", nenable_out); end
    checks++; if (nmute_out !== 2'b00) begin failures++; $display("FAIL reset_nmute got=%b exp=00", nmute_out); end
    checks++; if (cfg_req_out !== 1'b0 || cfg_ch_out !== 1'b0) begin failures++; $display("FAIL reset_cfg got=%b/%b exp=0/0", cfg_req_out, cfg_ch_out); end
    checks++; if (fault_out !== 2'b00) begin failures++; $display("FAIL reset_fault got=%b exp=00", fault_out); end
  endtask

  task automatic test_startup;
    reset = 1'b0; audio_locked_in = 1'b1;
    tick(9);
    checks++; if (cfg_req_out !== 1'b0) begin failures++; $display("FAIL startup_req_early got=%b exp=0", cfg_req_out); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b0) begin failures++; $display("FAIL startup_grant0 got=%b/%b exp=1/0", cfg_req_out, cfg_ch_out); end
    tick(4);
    pulse_done(1'b0);
    checks++; if (cfg_req_out !== 1'b0 || nenable_out !== 2'b10 || nmute_out !== 2'b00) begin failures++; $display("FAIL startup_done0 got req=%b nen=%b nmute=%b exp req=0 nen=10 nmute=00", cfg_req_out, nenable_out, nmute_out); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b1) begin failures++; $display("FAIL startup_grant1 got=%b/%b exp=1/1", cfg_req_out, cfg_ch_out); end
    tick(2);
    checks++; if (nmute_out !== 2'b00) begin failures++; $display("FAIL startup_mute_hold got=%b exp=00", nmute_out); end
    tick(1);
    checks++; if (nmute_out !== 2'b01) begin failures++; $display("FAIL startup_unmute0 got=%b exp=01", nmute_out); end
    pulse_done(1'b0);
    tick(4);
    checks++; if (nenable_out !== 2'b00 || nmute_out !== 2'b11 || fault_out !== 2'b00) begin failures++; $display("FAIL startup_both_play got nen=%b nmute=%b fault=%b exp 00/11/00", nenable_out, nmute_out, fault_out); end
  endtask

  task automatic test_lock_loss;
    audio_locked_in = 1'b0;
    tick(1);
    audio_locked_in = 1'b1;
    checks++; if (nmute_out !== 2'b00 || nenable_out !== 2'b00) begin failures++; $display("FAIL lockloss_mute got nmute=%b nen=%b exp 00/00", nmute_out, nenable_out); end
    tick(3);
    checks++; if (nmute_out !== 2'b00) begin failures++; $display("FAIL lockloss_hold got=%b exp=00", nmute_out); end
    tick(1);
    checks++; if (nmute_out !== 2'b11 || cfg_req_out !== 1'b0) begin failures++; $display("FAIL lockloss_relock got nmute=%b req=%b exp 11/0", nmute_out, cfg_req_out); end
  endtask

  task automatic test_fault;
    nerror_in = 2'b01;
    tick(2);
    checks++; if (fault_out !== 2'b00 || nenable_out !== 2'b00) begin failures++; $display("FAIL fault_early got fault=%b nen=%b exp 00/00", fault_out, nenable_out); end
    tick(1);
    checks++; if (fault_out !== 2'b10 || nenable_out !== 2'b10 || nmute_out !== 2'b01) begin failures++; $display("FAIL fault_react got fault=%b nen=%b nmute=%b exp 10/10/01", fault_out, nenable_out, nmute_out); end
  endtask

  task automatic test_lockout;
    tick(9);
    checks++; if (fault_out[1] !== 1'b1) begin failures++; $display("FAIL lockout_fault1 got=%b exp=1", fault_out[1]); end
    tick(1);
    checks++; if (fault_out[1] !== 1'b0 || nenable_out[1] !== 1'b1) begin failures++; $display("FAIL lockout_retry_off got fault=%b nen=%b exp 0/1", fault_out[1], nenable_out[1]); end
    tick(1);
    checks++; if (fault_out[1] !== 1'b1) begin failures++; $display("FAIL lockout_fault2 got=%b exp=1", fault_out[1]); end
    tick(10);
    checks++; if (fault_out[1] !== 1'b1) begin failures++; $display("FAIL lockout_enter got=%b exp=1", fault_out[1]); end
    tick(10);
    checks++; if (fault_out[1] !== 1'b1 || nenable_out[1] !== 1'b1 || cfg_req_out !== 1'b0) begin failures++; $display("FAIL lockout_hold got fault=%b nen=%b req=%b exp 1/1/0", fault_out[1], nenable_out[1], cfg_req_out); end
    checks++; if (nenable_out[0] !== 1'b0 || nmute_out[0] !== 1'b1) begin failures++; $display("FAIL lockout_ch0 got nen=%b nmute=%b exp 0/1", nenable_out[0], nmute_out[0]); end
    nerror_in = 2'b11;
    tick(3);
    clear_fault_in = 2'b10;
    tick(1);
    clear_fault_in = 2'b00;
    checks++; if (fault_out[1] !== 1'b0) begin failures++; $display("FAIL lockout_clear got=%b exp=0", fault_out[1]); end
    tick(2);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b1) begin failures++; $display("FAIL lockout_reconfig got=%b/%b exp=1/1", cfg_req_out, cfg_ch_out); end
    pulse_done(1'b0);
    tick(4);
    checks++; if (nmute_out !== 2'b11) begin failures++; $display("FAIL lockout_replay got=%b exp=11", nmute_out); end
  endtask

  task automatic test_cfg_fail;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b0) begin failures++; $display("FAIL cfgfail_grant0 got=%b/%b exp=1/0", cfg_req_out, cfg_ch_out); end
    pulse_done(1'b1);
    checks++; if (fault_out !== 2'b01 || cfg_req_out !== 1'b0) begin failures++; $display("FAIL cfgfail_nack got fault=%b req=%b exp 01/0", fault_out, cfg_req_out); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b1) begin failures++; $display("FAIL cfgfail_grant1 got=%b/%b exp=1/1", cfg_req_out, cfg_ch_out); end
    pulse_done(1'b0);
    tick(9);
    checks++; if (cfg_req_out !== 1'b0) begin failures++; $display("FAIL cfgfail_retry_wait got=%b exp=0", cfg_req_out); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b0 || fault_out[0] !== 1'b0) begin failures++; $display("FAIL cfgfail_regrant got req=%b ch=%b fault=%b exp 1/0/0", cfg_req_out, cfg_ch_out, fault_out[0]); end
    tick(19);
    checks++; if (cfg_req_out !== 1'b1 || fault_out[0] !== 1'b0) begin failures++; $display("FAIL cfgfail_pre_timeout got req=%b fault=%b exp 1/0", cfg_req_out, fault_out[0]); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b0 || fault_out[0] !== 1'b1) begin failures++; $display("FAIL cfgfail_timeout got req=%b fault=%b exp 0/1", cfg_req_out, fault_out[0]); end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    checks++; if (cfg_req_out !== 1'b1) begin failures++; $display("FAIL rstmid_grant got=%b exp=1", cfg_req_out); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checks++; if (cfg_req_out !== 1'b0 || nenable_out !== 2'b11 || nmute_out !== 2'b00 || fault_out !== 2'b00 || cfg_ch_out !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got req=%b nen=%b nmute=%b fault=%b ch=%b", cfg_req_out, nenable_out, nmute_out, fault_out, cfg_ch_out); end
    pulse_done(1'b0);
    checks++; if (cfg_req_out !== 1'b0 || nenable_out !== 2'b11) begin failures++; $display("FAIL rstmid_stale_done got req=%b nen=%b exp 0/11", cfg_req_out, nenable_out); end
    tick(8);
    checks++; if (cfg_req_out !== 1'b0) begin failures++; $display("FAIL rstmid_relock_early got=%b exp=0", cfg_req_out); end
    tick(1);
    checks++; if (cfg_req_out !== 1'b1 || cfg_ch_out !== 1'b0) begin failures++; $display("FAIL rstmid_regrant got=%b/%b exp=1/0", cfg_req_out, cfg_ch_out); end
    pulse_done(1'b0);
    checks++; if (nenable_out !== 2'b10) begin failures++; $display("FAIL rstmid_enable got=%b exp=10", nenable_out); end
  endtask

  initial begin
    test_reset;
    test_startup;
    test_lock_loss;
    test_fault;
    test_lockout;
    test_cfg_fail;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
